// File: rtl/ser_rr_sched_pkg.sv
// ser_pkg: shared types and frame-length derivation for the round-robin serializer.
// Build option: define SER_PARITY_EN to append an even-parity bit to every frame.
package ser_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int DW_DEF = 8;

`ifdef SER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Frame length for a given word width (parity bit rides after the MSB).
  function automatic int frame_len(input int dw);
    return dw + PAR_BITS;
  endfunction

endpackage

// File: rtl/ser_rr_sched_if.sv
// Requester bus plus serial output of the shared serializer.
interface ser_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               sout;
  logic               sout_valid;
  logic [IW-1:0]      grant_id;
  logic               done;

  // Producer / pin side.
  modport master (
    output req_valid, req_data,
    input  req_ready, sout, sout_valid, grant_id, done
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_data,
    output req_ready, sout, sout_valid, grant_id, done
  );
endinterface

// File: rtl/ser_rr_pick.sv
// ser_rr_pick: rotate-priority picker. Searches ptr+1, ptr+2, ... (mod NREQ)
// and returns the first valid requester as one-hot grant plus index.
module ser_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan farthest-to-nearest so the nearest valid after ptr overwrites the rest.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (valid[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ser_rr_sched.sv
// ser_rr_sched: round-robin scheduler in front of one LSB-first serializer.
// Build option: SER_PARITY_EN adds an even-parity bit after the MSB.
module ser_rr_sched
  import ser_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  ser_rr_sched_if.slave  sif
);

  localparam int FL = frame_len(DW);
  localparam int CW = $clog2(FL + 1);
  localparam int IW = $clog2(NREQ);
  localparam logic [CW-1:0] LAST = CW'(FL - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;
  logic [IW-1:0]   ptr;
  logic [FL-1:0]   frame_q;
  logic [FL-1:0]   frame_d;
  logic [DW-1:0]   word_in;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   win;
  logic            any;
  logic            last;
  logic            hs;

  ser_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .valid (sif.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  assign word_in = sif.req_data[int'(win)*DW +: DW];
  assign cnt_nx  = cnt + 1'b1;

`ifdef SER_PARITY_EN
  assign frame_d = {^word_in, word_in};
`else
  assign frame_d = word_in;
`endif

  // Grant window: idle, or the last bit of a frame so frames run back-to-back.
  assign last = (state == SHIFT) && (cnt == LAST);
  assign hs   = rst_n && any && ((state == IDLE) || last);
  assign sif.req_ready = hs ? grant : '0;

  // Frame FSM: latch on handshake, shift bits out, registered pin outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      ptr            <= IW'(NREQ - 1);
      frame_q        <= '0;
      sif.sout       <= 1'b0;
      sif.sout_valid <= 1'b0;
      sif.done       <= 1'b0;
      sif.grant_id   <= '0;
    end else if (hs) begin
      state          <= SHIFT;
      cnt            <= '0;
      ptr            <= win;
      frame_q        <= frame_d;
      sif.sout       <= frame_d[0];
      sif.sout_valid <= 1'b1;
      sif.done       <= (FL == 1);
      sif.grant_id   <= win;
    end else if (state == SHIFT && !last) begin
      cnt            <= cnt_nx;
      sif.sout       <= frame_q[cnt_nx];
      sif.done       <= (cnt_nx == LAST);
    end else begin
      state          <= IDLE;
      sif.sout       <= 1'b0;
      sif.sout_valid <= 1'b0;
      sif.done       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ser_rr_sched.sv
// Directed bench for ser_rr_sched (NREQ=4, DW=8).
module tb_ser_rr_sched;

`ifdef SER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  ser_rr_sched_if #(.NREQ(4), .DW(8)) bus ();

  ser_rr_sched #(.NREQ(4), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".sv"},   32'(bus.sout_valid), 32'd0);
    chk({tag, ".done"}, 32'(bus.done),       32'd0);
    chk({tag, ".sout"}, 32'(bus.sout),       32'd0);
  endtask

  // One frame: ready check, handshake, then every bit. Returns in the last bit
  // cycle so the caller can stage the next request for a back-to-back grant.
  task automatic frame(input int id, input logic [7:0] w, input bit scramble,
                       input logic [3:0] post_valid);
    logic eb;
    #1;
    chk("ready", 32'(bus.req_ready), 32'(4'b0001 << id));
    cyc();
    bus.req_valid = post_valid;
    if (scramble) bus.req_data[id*8 +: 8] = ~w;
    for (int i = 0; i < FL; i++) begin
      if (i < 8) eb = w[i];
      else       eb = ^w;
      chk("sout",  32'(bus.sout),       32'(eb));
      chk("sv",    32'(bus.sout_valid), 32'd1);
      chk("done",  32'(bus.done),       32'(i == FL - 1));
      chk("gid",   32'(bus.grant_id),   32'(id));
      if (i < FL - 1) begin
        chk("rdy_mid", 32'(bus.req_ready), 32'd0);
        cyc();
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] dv [4];
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_data  = '0;

    // Reset state, and ready forced low while reset is held.
    cyc();
    cyc();
    chk("rst.ready", 32'(bus.req_ready), 32'd0);
    chk("rst.gid",   32'(bus.grant_id),  32'd0);
    chk_idle("rst");
    bus.req_valid = 4'b0000;
    rst_n = 1'b1;
    cyc();

    // Single request, A5 -> 1,0,1,0,0,1,0,1.
    bus.req_data[7:0] = 8'hA5;
    bus.req_valid = 4'b0001;
    frame(0, 8'hA5, 1'b0, 4'b0000);
    cyc();
    chk_idle("single");

    // Continuous demand from all: grants 0,1,2,3,0 with no gaps.
    do_reset();
    dv[0] = 8'h01; dv[1] = 8'h02; dv[2] = 8'h04; dv[3] = 8'h08;
    bus.req_data  = {8'h08, 8'h04, 8'h02, 8'h01};
    bus.req_valid = 4'b1111;
    for (int f = 0; f < 5; f++)
      frame(f % 4, dv[f % 4], 1'b0, (f == 4) ? 4'b0000 : 4'b1111);
    cyc();
    chk_idle("all");

    // Requesters 1 and 3: after grant 1 comes 3, then 1.
    bus.req_data  = {8'h33, 8'h00, 8'h11, 8'h00};
    bus.req_valid = 4'b0010;
    frame(1, 8'h11, 1'b0, 4'b0000);
    bus.req_valid = 4'b1010;
    frame(3, 8'h33, 1'b0, 4'b1010);
    frame(1, 8'h11, 1'b0, 4'b0000);
    cyc();
    chk_idle("rr13");

    // Data change after handshake does not disturb the frame in flight.
    bus.req_data[23:16] = 8'h3C;
    bus.req_valid = 4'b0100;
    frame(2, 8'h3C, 1'b1, 4'b0000);
    cyc();
    chk_idle("hold");

    // Reset at the 4th bit of a frame: abort, then requester 0 wins.
    bus.req_data  = {8'h08, 8'h5A, 8'h02, 8'hC3};
    bus.req_valid = 4'b0100;
    #1;
    chk("abort.ready", 32'(bus.req_ready), 32'b0100);
    cyc();
    bus.req_valid = 4'b0000;
    cyc();
    cyc();
    cyc();
    chk("abort.b3", 32'(bus.sout), 32'd1);
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    chk("abort.rdy_rst", 32'(bus.req_ready), 32'd0);
    cyc();
    chk("abort.gid", 32'(bus.grant_id), 32'd0);
    chk_idle("abort");
    rst_n = 1'b1;
    frame(0, 8'hC3, 1'b0, 4'b0000);
    cyc();
    chk_idle("post");

    // 07: parity bit 1 as 9th bit when enabled, else done on 8th bit.
    bus.req_data[7:0] = 8'h07;
    bus.req_valid = 4'b0001;
    frame(0, 8'h07, 1'b0, 4'b0000);
    cyc();
    chk_idle("par");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
